// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: sums signed Booth products per burst, returns sum, beat count and sticky overflow
module booth_product_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] out_count,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] prod_ext, sum;
    logic             accept, add_ovf, done;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !out_valid;
    assign accept    = in_valid && in_ready;
    assign done      = out_valid && out_ready;
    assign acc_out   = acc_q;
    assign out_count = cnt_q;
    assign overflow  = ovf_q;

    // Adder with sign-extended product; overflow when like-signed addends yield an opposite-signed sum
    always_comb begin
        prod_ext = {{(ACC_W-32){product[31]}}, product};
        sum      = acc_q + prod_ext;
        add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    end

    // Next-state and datapath update: accumulate on accepted beats, clear on result handshake
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d   = sum;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    ovf_d   = ovf_q || add_ovf;
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (done) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and accumulator registers; reset discards any partial or pending result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb_booth_product_accumulator: scoreboard bench for booth_product_accumulator
module tb_booth_product_accumulator;

    localparam int ACC_W = 40;
    localparam int CNT_W = 8;
    localparam longint ACC_MAX = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W-1));

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      product = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] out_count;
    logic             overflow;

    typedef struct {
        longint acc;
        int     cnt;
        bit     ovf;
    } res_t;

    res_t   exp_q[$];
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_ovf = 1'b0;
    int     checks = 0;
    int     failures = 0;

    booth_product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .product(product), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .acc_out(acc_out), .out_count(out_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint acc_s();
        logic signed [ACC_W-1:0] t;
        t = acc_out;
        return longint'(t);
    endfunction

    // Drive one beat, wait (bounded) until accepted, update the reference model
    task automatic send(input logic signed [31:0] p, input logic last, output int waited);
        longint s;
        logic signed [ACC_W-1:0] w;
        in_valid = 1'b1;
        product  = p;
        in_last  = last;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        s = m_acc + longint'(p);
        if (s > ACC_MAX || s < ACC_MIN) m_ovf = 1'b1;
        w = s[ACC_W-1:0];
        m_acc = longint'(w);
        m_cnt = (m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1;
        if (last) begin
            exp_q.push_back('{m_acc, m_cnt, m_ovf});
            m_acc = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    // Result monitor: compare every completed output handshake with the scoreboard
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    check("sb_acc", acc_s(), r.acc);
                    check("sb_cnt", longint'(out_count), longint'(r.cnt));
                    check("sb_ovf", longint'(overflow), longint'(r.ovf));
                end
            end
        end
    end

    initial begin
        int w;
        #2;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_acc", acc_s(), 0);
        check("rst_cnt", longint'(out_count), 0);
        check("rst_ovf", longint'(overflow), 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'sd5807370, 1'b1, w);
        check("single_valid", longint'(out_valid), 1);
        check("single_acc", acc_s(), 5807370);
        check("single_cnt", longint'(out_count), 1);
        check("single_ovf", longint'(overflow), 0);
        @(posedge clk);
        #1;
        check("single_ready_after", longint'(in_ready), 1);
        check("single_valid_after", longint'(out_valid), 0);
        check("single_acc_clear", acc_s(), 0);
        check("single_cnt_clear", longint'(out_count), 0);

        send(-32'sd1073709056, 1'b0, w);
        send(32'sd1073709056, 1'b0, w);
        check("mixed_no_early_valid", longint'(out_valid), 0);
        send(-32'sd9930, 1'b1, w);
        check("mixed_valid", longint'(out_valid), 1);
        check("mixed_acc", acc_s(), -9930);
        check("mixed_cnt", longint'(out_count), 3);
        check("mixed_ovf", longint'(overflow), 0);

        for (int i = 0; i < 4; i++) send(32'sd1073741824, i == 3, w);
        check("wide_acc", acc_s(), 64'sd4294967296);
        check("wide_ovf", longint'(overflow), 0);

        for (int i = 0; i < 512; i++) send(32'sd1073741824, i == 511, w);
        check("ovf_acc", acc_s(), -64'sd549755813888);
        check("ovf_flag", longint'(overflow), 1);
        check("ovf_cnt_sat", longint'(out_count), 255);

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'sd1000, 1'b0, w);
        send(32'sd2000, 1'b1, w);
        in_valid = 1'b1;
        product  = -32'sd9930;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", longint'(in_ready), 0);
            check("bp_out_valid", longint'(out_valid), 1);
            check("bp_acc", acc_s(), 3000);
            check("bp_cnt", longint'(out_count), 2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(-32'sd9930, 1'b1, w);
        check("bp_wait_cycles", longint'(w), 1);
        check("bp_pending_acc", acc_s(), -9930);
        check("bp_pending_cnt", longint'(out_count), 1);

        @(posedge clk);
        #1;
        send(32'sd1073676289, 1'b0, w);
        send(32'sd1073676289, 1'b0, w);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_acc", acc_s(), 0);
        check("mid_rst_cnt", longint'(out_count), 0);
        check("mid_rst_ovf", longint'(overflow), 0);
        check("mid_rst_ready", longint'(in_ready), 1);
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(-32'sd50, 1'b1, w);
        check("post_rst_acc", acc_s(), -50);
        check("post_rst_cnt", longint'(out_count), 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("sb_drained", longint'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
